logic_gate_pipe: RTL

Parametrised successor to the single-bit two-input gate block. It applies a runtime-selected bitwise logic operation to two WIDTH-bit operands and provides two results: a combinational result and a pipelined registered result with a valid flag. An optional saturating counter tracks non-zero results for on-board debug. It sits between input synchronisers or switch decoders and downstream LED/status logic on the single system clock.

---
 rtl/logic_gate_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// Runtime-selected bitwise gate on two WIDTH-bit operands with a combinational result
// and a DEPTH-cycle registered result; the optional hit counter is enabled by LOGIC_PIPE_CNT_EN.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_valid,
    input  logic [WIDTH-1:0] pi_a,
    input  logic [WIDTH-1:0] pi_b,
    input  logic [1:0]       pi_op,
    input  logic             pi_clr,
    output logic [WIDTH-1:0] po_c1,
    output logic [WIDTH-1:0] po_c2,
    output logic             po_valid,
    output logic [CNT_W-1:0] po_hit_cnt
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    logic [WIDTH-1:0] result;
    logic             feed_vld;
    logic [WIDTH-1:0] feed_data;
    logic [WIDTH-1:0] c2_q;
    logic             valid_q;

    always_comb begin
        result = '0;
        case (op_e'(pi_op))
            OP_AND:  result = pi_a & pi_b;
            OP_OR:   result = pi_a | pi_b;
            OP_XOR:  result = pi_a ^ pi_b;
            OP_NAND: result = ~(pi_a & pi_b);
            default: result = '0;
        endcase
    end

    assign po_c1 = result;

    // The output register is the last of the DEPTH registers, so only DEPTH-1 shift stages sit in front of it.
    generate
        if (DEPTH == 1) begin : g_direct
            assign feed_vld  = pi_valid;
            assign feed_data = result;
        end else begin : g_stages
            localparam int NS = DEPTH - 1;
            logic [NS-1:0]    vld_q;
            logic [WIDTH-1:0] data_q [NS];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < NS; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= pi_valid;
                    data_q[0] <= result;
                    for (int i = 1; i < NS; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign feed_vld  = vld_q[NS-1];
            assign feed_data = data_q[NS-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            c2_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= feed_vld;
            if (feed_vld) begin
                c2_q <= feed_data;
            end
        end
    end

    assign po_c2    = c2_q;
    assign po_valid = valid_q;

`ifdef LOGIC_PIPE_CNT_EN
    logic             hit;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit = feed_vld && (feed_data != '0);

    // Clear beats a coincident increment; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (pi_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign po_hit_cnt = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = pi_clr;
    assign po_hit_cnt = '0;
`endif

endmodule
